// File: rtl/me_sad_engine_pkg.sv
// Shared types and width helpers for the block-matching motion estimator.
package me_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Tag vector fields are wide enough for RANGE up to 128.
  localparam int TAG_VW = 8;

  typedef struct packed {
    logic                     valid;
    logic                     last;
    logic signed [TAG_VW-1:0] dx;
    logic signed [TAG_VW-1:0] dy;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, last: 1'b0, dx: 8'sd0, dy: 8'sd0};

  function automatic int sad_w(input int pix_w, input int blk);
    return pix_w + 2 * $clog2(blk);
  endfunction

  function automatic int sw_edge(input int blk, input int range);
    return blk + 2 * range - 1;
  endfunction

  function automatic int addr_r_w(input int blk);
    return $clog2(blk * blk);
  endfunction

  function automatic int addr_s_w(input int blk, input int range);
    return $clog2(sw_edge(blk, range) * sw_edge(blk, range));
  endfunction

  function automatic int vec_w(input int range);
    return $clog2(range) + 1;
  endfunction

endpackage

// File: rtl/me_sad_engine_if.sv
// Reference/search ROM port bundle; master is the engine, slave is the memory.
interface me_sad_engine_if #(
  parameter int PIX_W = 8,
  parameter int BLK   = 16,
  parameter int RANGE = 8
) ();
  import me_pkg::*;

  localparam int AR_W = addr_r_w(BLK);
  localparam int AS_W = addr_s_w(BLK, RANGE);

  logic [AR_W-1:0]  AddressR;
  logic [PIX_W-1:0] R;
  logic [AS_W-1:0]  AddressS;
  logic [PIX_W-1:0] S;

  modport master (output AddressR, output AddressS, input R, input S);
  modport slave  (input AddressR, input AddressS, output R, output S);

endinterface

// File: rtl/me_sad_engine_accum.sv
// Stages 1-2: abs-diff, SAD accumulate, best compare and early-termination abort.
module me_sad_accum
  import me_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int BLK   = 16,
  parameter int RANGE = 8,
  localparam int SAD_W = sad_w(PIX_W, BLK),
  localparam int V_W   = vec_w(RANGE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_early,
  input  tag_t                  i_tag0,
  input  logic [PIX_W-1:0]      i_r,
  input  logic [PIX_W-1:0]      i_s,
  output logic                  o_cut,
  output logic [SAD_W-1:0]      o_best,
  output logic signed [V_W-1:0] o_mx,
  output logic signed [V_W-1:0] o_my
);

  tag_t                  r_tag1;
  logic [SAD_W-1:0]      r_acc;
  logic [SAD_W-1:0]      r_best;
  logic signed [V_W-1:0] r_mx;
  logic signed [V_W-1:0] r_my;
  logic                  r_have_best;

  logic [PIX_W-1:0]      w_diff;
  logic [SAD_W-1:0]      w_sum;
  logic                  w_take;
  logic                  w_abort;
  logic                  w_same_cand;

  // Abs-diff, running sum, strict-less compare and abort decision
  always_comb begin
    if (i_r >= i_s) begin
      w_diff = i_r - i_s;
    end else begin
      w_diff = i_s - i_r;
    end
    w_sum       = r_acc + SAD_W'(w_diff);
    w_take      = r_tag1.valid && r_tag1.last && (!r_have_best || (w_sum < r_best));
    w_abort     = i_early && r_tag1.valid && !r_tag1.last && r_have_best && (w_sum >= r_best);
    w_same_cand = (i_tag0.dx == r_tag1.dx) && (i_tag0.dy == r_tag1.dy);
    // The read in stage 0 is dropped only if it belongs to the aborted candidate
    o_cut       = w_abort && i_tag0.valid && w_same_cand;
  end

  // Stage-1 tag, travelling alongside the ROM read data
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tag1 <= TAG_IDLE;
    end else if (o_cut) begin
      r_tag1 <= TAG_IDLE;
    end else begin
      r_tag1 <= i_tag0;
    end
  end

  // SAD accumulator, cleared at each candidate boundary or abort
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc <= {SAD_W{1'b0}};
    end else if (i_start) begin
      r_acc <= {SAD_W{1'b0}};
    end else if (r_tag1.valid && (r_tag1.last || w_abort)) begin
      r_acc <= {SAD_W{1'b0}};
    end else if (r_tag1.valid) begin
      r_acc <= w_sum;
    end else begin
      r_acc <= r_acc;
    end
  end

  // Best SAD and vector; previous results stay visible until the first compare
  always_ff @(posedge clock) begin
    if (reset) begin
      r_best      <= {SAD_W{1'b0}};
      r_mx        <= {V_W{1'b0}};
      r_my        <= {V_W{1'b0}};
      r_have_best <= 1'b0;
    end else if (i_start) begin
      r_have_best <= 1'b0;
    end else if (w_take) begin
      r_best      <= w_sum;
      r_mx        <= V_W'(r_tag1.dx);
      r_my        <= V_W'(r_tag1.dy);
      r_have_best <= 1'b1;
    end else begin
      r_have_best <= r_have_best;
    end
  end

  assign o_best = r_best;
  assign o_mx   = r_mx;
  assign o_my   = r_my;

endmodule

// File: rtl/me_sad_engine.sv
// Full-search motion estimator top: FSM, scan counters and ROM address issue (stage 0).
module me_sad_engine
  import me_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int BLK   = 16,
  parameter int RANGE = 8,
  localparam int SAD_W = sad_w(PIX_W, BLK),
  localparam int V_W   = vec_w(RANGE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  early_term,
  me_sad_engine_if.master       mem,
  output logic [SAD_W-1:0]      BestDist,
  output logic signed [V_W-1:0] motionX,
  output logic signed [V_W-1:0] motionY,
  output logic                  busy,
  output logic                  completed
);

  localparam int SW   = sw_edge(BLK, RANGE);
  localparam int AR_W = addr_r_w(BLK);
  localparam int AS_W = addr_s_w(BLK, RANGE);
  localparam int IJ_W = $clog2(BLK);
  localparam logic [IJ_W-1:0]       IJ_MAX  = IJ_W'(BLK - 1);
  localparam logic [IJ_W-1:0]       IJ_ONE  = IJ_W'(1);
  localparam logic signed [V_W-1:0] V_MIN   = V_W'(-RANGE);
  localparam logic signed [V_W-1:0] V_MAX   = V_W'(RANGE - 1);
  localparam logic signed [V_W-1:0] V_ONE   = V_W'(1);
  // Two extra drain cycles after the final accumulate give the fixed completion latency
  localparam logic [1:0]            DRAIN_LAST = 2'd2;

  state_t                r_state, w_state_next;
  logic [1:0]            r_drain_cnt;
  logic                  r_busy, r_completed, w_busy_next, w_completed_next;
  logic                  r_early;
  logic [IJ_W-1:0]       r_i, r_j, w_i_next, w_j_next;
  logic signed [V_W-1:0] r_dx, r_dy, w_dx_next, w_dy_next;
  tag_t                  r_tag0, w_tag0_next;
  logic [AR_W-1:0]       r_addr_r, w_addr_r_next;
  logic [AS_W-1:0]       r_addr_s, w_addr_s_next;
  int                    w_row, w_col;
  logic                  w_accept, w_cut, w_pix_last, w_cand_last, w_cand_end, w_search_end;

  assign w_accept     = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_pix_last   = (r_i == IJ_MAX) && (r_j == IJ_MAX);
  assign w_cand_last  = (r_dx == V_MAX) && (r_dy == V_MAX);
  assign w_cand_end   = w_pix_last || w_cut;
  assign w_search_end = (r_state == RUN) && w_cand_end && w_cand_last;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = RUN; else w_state_next = IDLE;
      RUN:     if (w_search_end) w_state_next = DRAIN; else w_state_next = RUN;
      DRAIN:   if (r_drain_cnt == DRAIN_LAST) w_state_next = DONE; else w_state_next = DRAIN;
      DONE:    if (w_accept) w_state_next = RUN; else w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode from the next state so busy/completed are registered
  always_comb begin
    w_busy_next      = (w_state_next == RUN) || (w_state_next == DRAIN);
    w_completed_next = (w_state_next == DONE);
  end

  // Status output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_completed <= 1'b0;
    end else begin
      r_busy      <= w_busy_next;
      r_completed <= w_completed_next;
    end
  end

  // Drain cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_drain_cnt <= 2'd0;
    end else if (r_state == DRAIN) begin
      r_drain_cnt <= r_drain_cnt + 2'd1;
    end else begin
      r_drain_cnt <= 2'd0;
    end
  end

  // Scan position: dy outer, dx inner, then row-major pixels; abort skips to the next candidate
  always_comb begin
    w_i_next  = r_i;
    w_j_next  = r_j;
    w_dx_next = r_dx;
    w_dy_next = r_dy;
    if (w_accept) begin
      w_i_next  = {IJ_W{1'b0}};
      w_j_next  = {IJ_W{1'b0}};
      w_dx_next = V_MIN;
      w_dy_next = V_MIN;
    end else if ((r_state == RUN) && !w_search_end) begin
      if (w_cand_end) begin
        w_i_next = {IJ_W{1'b0}};
        w_j_next = {IJ_W{1'b0}};
        if (r_dx == V_MAX) begin
          w_dx_next = V_MIN;
          w_dy_next = r_dy + V_ONE;
        end else begin
          w_dx_next = r_dx + V_ONE;
        end
      end else if (r_j == IJ_MAX) begin
        w_j_next = {IJ_W{1'b0}};
        w_i_next = r_i + IJ_ONE;
      end else begin
        w_j_next = r_j + IJ_ONE;
      end
    end else begin
      w_i_next = r_i;
    end
  end

  // Stage-0 tag and ROM addresses for the next issued pixel pair
  always_comb begin
    w_tag0_next       = TAG_IDLE;
    w_tag0_next.valid = w_accept || ((r_state == RUN) && !w_search_end);
    w_tag0_next.last  = (w_i_next == IJ_MAX) && (w_j_next == IJ_MAX);
    w_tag0_next.dx    = TAG_VW'(w_dx_next);
    w_tag0_next.dy    = TAG_VW'(w_dy_next);
    w_row             = int'(w_i_next) + int'(w_dy_next) + RANGE;
    w_col             = int'(w_j_next) + int'(w_dx_next) + RANGE;
    if (w_tag0_next.valid) begin
      w_addr_r_next = {w_i_next, w_j_next};
      w_addr_s_next = AS_W'(w_row * SW + w_col);
    end else begin
      w_addr_r_next = r_addr_r;
      w_addr_s_next = r_addr_s;
    end
  end

  // Stage-0 registers: scan position, tag, addresses and latched mode
  always_ff @(posedge clock) begin
    if (reset) begin
      r_i      <= {IJ_W{1'b0}};
      r_j      <= {IJ_W{1'b0}};
      r_dx     <= {V_W{1'b0}};
      r_dy     <= {V_W{1'b0}};
      r_tag0   <= TAG_IDLE;
      r_addr_r <= {AR_W{1'b0}};
      r_addr_s <= {AS_W{1'b0}};
      r_early  <= 1'b0;
    end else begin
      r_i      <= w_i_next;
      r_j      <= w_j_next;
      r_dx     <= w_dx_next;
      r_dy     <= w_dy_next;
      r_tag0   <= w_tag0_next;
      r_addr_r <= w_addr_r_next;
      r_addr_s <= w_addr_s_next;
      r_early  <= w_accept ? early_term : r_early;
    end
  end

  me_sad_accum #(
    .PIX_W (PIX_W),
    .BLK   (BLK),
    .RANGE (RANGE)
  ) u_accum (
    .clock   (clock),
    .reset   (reset),
    .i_start (w_accept),
    .i_early (r_early),
    .i_tag0  (r_tag0),
    .i_r     (mem.R),
    .i_s     (mem.S),
    .o_cut   (w_cut),
    .o_best  (BestDist),
    .o_mx    (motionX),
    .o_my    (motionY)
  );

  assign mem.AddressR = r_addr_r;
  assign mem.AddressS = r_addr_s;
  assign busy         = r_busy;
  assign completed    = r_completed;

endmodule

// File: tb/tb_me_sad_engine.sv
// Self-checking bench for me_sad_engine (BLK=4, RANGE=2): table of image/mode
// vectors against a full-search reference model, plus restart/reset sequences.
module tb_me_sad_engine;
  import me_pkg::*;

  localparam int PIX_W = 8;
  localparam int BLK   = 4;
  localparam int RANGE = 2;
  localparam int SW    = BLK + 2 * RANGE - 1;
  localparam int NR    = BLK * BLK;
  localparam int NS    = SW * SW;
  localparam int FULL  = (2 * RANGE) * (2 * RANGE) * NR + 3;
  localparam int N_IMG = 6;
  localparam int N_VEC = 10;

  // cyc_mode: 0 exact, 1 strictly less than FULL, 2 at most FULL
  typedef struct {
    int img;
    bit early;
    int exp_dist;
    int exp_mx;
    int exp_my;
    int exp_cyc;
    int cyc_mode;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset, start, early_term;
  logic [11:0] BestDist;
  logic [1:0]  motionX, motionY;
  logic        busy, completed;

  logic [7:0] ref_mem [NR];
  logic [7:0] win_mem [NS];
  logic [7:0] img_r [N_IMG][NR];
  logic [7:0] img_w [N_IMG][NS];
  vec_t       tbl [N_VEC];

  int n_tests = 0;
  int n_fail  = 0;

  me_sad_engine_if #(.PIX_W(PIX_W), .BLK(BLK), .RANGE(RANGE)) bus ();

  me_sad_engine #(.PIX_W(PIX_W), .BLK(BLK), .RANGE(RANGE)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .early_term (early_term),
    .mem        (bus),
    .BestDist   (BestDist),
    .motionX    (motionX),
    .motionY    (motionY),
    .busy       (busy),
    .completed  (completed)
  );

  always #5 clock = ~clock;

  // Synchronous ROMs: data one cycle after address
  always @(posedge clock) begin
    bus.R <= ref_mem[bus.AddressR];
    bus.S <= win_mem[bus.AddressS];
  end

  task automatic check(input string name, input bit ok, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_best"}, BestDist == 12'd0, int'(BestDist), 0);
    check({tag, "_mx"}, motionX == 2'd0, int'(motionX), 0);
    check({tag, "_my"}, motionY == 2'd0, int'(motionY), 0);
    check({tag, "_completed"}, completed == 1'b0, int'(completed), 0);
    check({tag, "_busy"}, busy == 1'b0, int'(busy), 0);
    check({tag, "_addr_r"}, bus.AddressR == 4'd0, int'(bus.AddressR), 0);
    check({tag, "_addr_s"}, bus.AddressS == 6'd0, int'(bus.AddressS), 0);
  endtask

  task automatic load(input int img);
    for (int p = 0; p < NR; p++) ref_mem[p] = img_r[img][p];
    for (int p = 0; p < NS; p++) win_mem[p] = img_w[img][p];
  endtask

  // Exhaustive search straight from the definition: first strict minimum in scan order
  function automatic void model(output int d, output int mx, output int my);
    int s, a, b;
    d = -1; mx = 0; my = 0;
    for (int dy = -RANGE; dy < RANGE; dy++) begin
      for (int dx = -RANGE; dx < RANGE; dx++) begin
        s = 0;
        for (int i = 0; i < BLK; i++) begin
          for (int j = 0; j < BLK; j++) begin
            a = int'(ref_mem[i * BLK + j]);
            b = int'(win_mem[(i + dy + RANGE) * SW + (j + dx + RANGE)]);
            s += (a > b) ? a - b : b - a;
          end
        end
        if (d < 0 || s < d) begin
          d = s; mx = dx; my = dy;
        end
      end
    end
  endfunction

  task automatic copy_ref_into_win(input int img, input int dx, input int dy);
    for (int i = 0; i < BLK; i++)
      for (int j = 0; j < BLK; j++)
        img_w[img][(i + dy + RANGE) * SW + (j + dx + RANGE)] = img_r[img][i * BLK + j];
  endtask

  task automatic run_search(input bit early, input bit re_pulse, input int hold_exp,
                            output int cyc, output bit busy_ok);
    @(negedge clock);
    early_term = early;
    start      = 1'b1;
    @(negedge clock);
    start      = 1'b0;
    early_term = 1'b0;
    cyc        = 0;
    busy_ok    = busy;
    if (hold_exp >= 0) begin
      check("restart_completed_low", completed == 1'b0, int'(completed), 0);
      check("restart_best_held", int'(BestDist) == hold_exp, int'(BestDist), hold_exp);
    end
    while (!completed && cyc < 2 * FULL) begin
      if (re_pulse && cyc == 20) start = 1'b1;
      if (re_pulse && cyc == 21) start = 1'b0;
      @(negedge clock);
      cyc++;
      if (!completed && !busy) busy_ok = 1'b0;
    end
    if (busy) busy_ok = 1'b0;
  endtask

  task automatic check_result(input string name, input vec_t v, input int cyc, input bit busy_ok);
    bit cyc_ok;
    case (v.cyc_mode)
      0:       cyc_ok = (cyc == v.exp_cyc);
      1:       cyc_ok = (cyc < v.exp_cyc);
      default: cyc_ok = (cyc <= v.exp_cyc);
    endcase
    check({name, "_completed"}, completed == 1'b1, int'(completed), 1);
    check({name, "_dist"}, int'(BestDist) == v.exp_dist, int'(BestDist), v.exp_dist);
    check({name, "_mx"}, int'($signed(motionX)) == v.exp_mx, int'($signed(motionX)), v.exp_mx);
    check({name, "_my"}, int'($signed(motionY)) == v.exp_my, int'($signed(motionY)), v.exp_my);
    check({name, "_cycles"}, cyc_ok, cyc, v.exp_cyc);
    check({name, "_busy"}, busy_ok, int'(busy_ok), 1);
  endtask

  initial begin
    int d, mx, my, cyc;
    bit bok;
    vec_t v;

    reset = 1'b1; start = 1'b0; early_term = 1'b0;
    for (int k = 0; k < N_IMG; k++) begin
      for (int p = 0; p < NR; p++) img_r[k][p] = 8'($urandom_range(0, 255));
      for (int p = 0; p < NS; p++) img_w[k][p] = 8'($urandom_range(0, 255));
    end
    copy_ref_into_win(0, 1, -2);
    for (int p = 0; p < NR; p++) img_r[1][p] = 8'd0;
    for (int p = 0; p < NS; p++) img_w[1][p] = 8'd255;
    for (int p = 0; p < NS; p++) img_w[2][p] = 8'd7;
    copy_ref_into_win(5, -2, -2);

    tbl[0] = '{0, 1'b0, 0, 1, -2, FULL, 0};
    tbl[1] = '{0, 1'b1, 0, 1, -2, FULL, 1};
    tbl[2] = '{1, 1'b0, 255 * NR, -2, -2, FULL, 0};
    tbl[3] = '{2, 1'b0, 0, -2, -2, FULL, 0};
    tbl[4] = '{2, 1'b1, 0, -2, -2, FULL, 2};
    tbl[5] = '{3, 1'b0, 0, 0, 0, FULL, 0};
    tbl[6] = '{3, 1'b1, 0, 0, 0, FULL, 2};
    tbl[7] = '{4, 1'b0, 0, 0, 0, FULL, 0};
    tbl[8] = '{4, 1'b1, 0, 0, 0, FULL, 2};
    tbl[9] = '{5, 1'b1, 0, -2, -2, FULL, 1};
    for (int k = 3; k <= 8; k++) begin
      load(tbl[k].img);
      model(d, mx, my);
      tbl[k].exp_dist = d;
      if (k >= 5) begin
        tbl[k].exp_mx = mx;
        tbl[k].exp_my = my;
      end
    end

    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;

    for (int k = 0; k < N_VEC; k++) begin
      load(tbl[k].img);
      run_search(tbl[k].early, 1'b0, -1, cyc, bok);
      check_result($sformatf("vec%0d", k), tbl[k], cyc, bok);
    end

    // Restart from DONE: completed drops at once, old result held until first compare
    load(1);
    run_search(1'b0, 1'b0, -1, cyc, bok);
    check_result("pre_restart", tbl[2], cyc, bok);
    load(0);
    run_search(1'b0, 1'b0, 255 * NR, cyc, bok);
    check_result("restart", tbl[0], cyc, bok);

    // start re-pulsed while busy is ignored
    load(4);
    run_search(1'b0, 1'b1, -1, cyc, bok);
    check_result("repulse", tbl[7], cyc, bok);

    // Reset in the middle of RUN, then a clean full search
    load(3);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (60) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("midreset");
    reset = 1'b0;
    run_search(1'b0, 1'b0, -1, cyc, bok);
    check_result("after_reset", tbl[5], cyc, bok);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
